// File: rtl/frogger_pkg.sv
// Shared game definitions: state encodings and default game parameters used by
// the game top and by the state controller.
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_P1_WINS = 2'b10,
    ST_CLEANUP = 2'b11
  } game_state_e;

  localparam int LIVES_DEFAULT     = 3;
  localparam int WIN_SCORE_DEFAULT = 10;

endpackage

// File: rtl/frogger_state_ctrl_if.sv
// Bundle of the game-control signals between the player/collision side and the
// state controller; the controller exposes its state directly on o_State.
interface frogger_state_ctrl_if;
  import frogger_pkg::*;

  logic       game_start;
  logic       collided;
  logic [6:0] score;
  logic [1:0] state;
  logic       game_active;
  logic       frog_reset;
  logic       clear_score;
  logic [1:0] lives;
  logic       game_over;

  modport master (
    output game_start, collided, score,
    input  state, game_active, frog_reset, clear_score, lives, game_over
  );

  modport slave (
    input  game_start, collided, score,
    output state, game_active, frog_reset, clear_score, lives, game_over
  );
endinterface

// File: rtl/edge_detect_rise.sv
// Rising-edge detector; a level already high when reset releases is not an edge
// until the input has been seen low at least once.
module edge_detect_rise (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sig,
  output logic o_Rise
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= i_Sig;
      armed_q <= armed_q | ~i_Sig;
    end
  end

  assign o_Rise = i_Sig & ~prev_q & armed_q;

endmodule

// File: rtl/frogger_state_ctrl.sv
// Frogger game state controller: start/cleanup sequencing, lives, post-collision
// freeze and win detection. All outputs are registered.
module frogger_state_ctrl
  import frogger_pkg::*;
#(
  parameter int c_LIVES         = LIVES_DEFAULT,
  parameter int c_WIN_SCORE     = WIN_SCORE_DEFAULT,
  parameter int c_DEATH_TICKS   = 25000000,
  parameter int c_CLEANUP_TICKS = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Game_Start,
  input  logic       i_Collided,
  input  logic [6:0] i_Score,
  output logic [1:0] o_State,
  output logic       o_Game_Active,
  output logic       o_Frog_Reset,
  output logic       o_Clear_Score,
  output logic [1:0] o_Lives,
  output logic       o_Game_Over
);

  localparam int FW = $clog2(c_DEATH_TICKS + 1);
  localparam int CW = $clog2(c_CLEANUP_TICKS + 1);

  game_state_e   state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic          active_q, active_d;
  logic          frog_q, frog_d;
  logic          clear_q, clear_d;
  logic          over_q, over_d;
  logic [FW-1:0] freeze_q, freeze_d;
  logic [CW-1:0] clean_q, clean_d;
  logic          start_rise;
  logic          coll_rise;

  edge_detect_rise u_start_edge (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Sig  (i_Game_Start),
    .o_Rise (start_rise)
  );

  edge_detect_rise u_coll_edge (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Sig  (i_Collided),
    .o_Rise (coll_rise)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      lives_q  <= 2'(c_LIVES);
      active_q <= 1'b0;
      frog_q   <= 1'b0;
      clear_q  <= 1'b0;
      over_q   <= 1'b0;
      freeze_q <= '0;
      clean_q  <= '0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      active_q <= active_d;
      frog_q   <= frog_d;
      clear_q  <= clear_d;
      over_q   <= over_d;
      freeze_q <= freeze_d;
      clean_q  <= clean_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    active_d = active_q;
    frog_d   = 1'b0;
    clear_d  = 1'b0;
    over_d   = over_q;
    freeze_d = freeze_q;
    clean_d  = clean_q;
    case (state_q)
      ST_IDLE, ST_P1_WINS: begin
        active_d = 1'b0;
        if (start_rise) begin
          state_d = ST_CLEANUP;
          clear_d = 1'b1;
          lives_d = 2'(c_LIVES);
          over_d  = 1'b0;
          clean_d = CW'(c_CLEANUP_TICKS - 1);
        end
      end
      ST_CLEANUP: begin
        if (clean_q == '0) begin
          state_d  = ST_RUNNING;
          frog_d   = 1'b1;
          active_d = 1'b1;
        end else begin
          clean_d = clean_q - CW'(1);
        end
      end
      ST_RUNNING: begin
        // The freeze masks both collisions and wins until the frog respawns.
        if (freeze_q != '0) begin
          freeze_d = freeze_q - FW'(1);
          if (freeze_q == FW'(1)) begin
            frog_d   = 1'b1;
            active_d = 1'b1;
          end
        end else if (i_Score >= 7'(c_WIN_SCORE)) begin
          state_d  = ST_P1_WINS;
          active_d = 1'b0;
        end else if (coll_rise) begin
          active_d = 1'b0;
          if (lives_q > 2'd1) begin
            lives_d  = lives_q - 2'd1;
            freeze_d = FW'(c_DEATH_TICKS);
          end else begin
            lives_d = 2'd0;
            over_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_State       = state_q;
  assign o_Game_Active = active_q;
  assign o_Frog_Reset  = frog_q;
  assign o_Clear_Score = clear_q;
  assign o_Lives       = lives_q;
  assign o_Game_Over   = over_q;

endmodule

// File: doc/frogger_state_ctrl.md
FROGGER_STATE_CTRL -- requirements
Module: frogger_state_ctrl

Interface
REQ-001 The module SHALL have parameter c_LIVES, default 3, meaning lives loaded at game start (1..3).
REQ-002 The module SHALL have parameter c_WIN_SCORE, default 10, meaning the score value that ends the game as a win (1..99).
REQ-003 The module SHALL have parameter c_DEATH_TICKS, default 25000000, meaning the freeze length after a collision, in clocks.
REQ-004 The module SHALL have parameter c_CLEANUP_TICKS, default 16, meaning the CLEANUP state length, in clocks.
REQ-005 The module SHALL have these ports, one per line, as name, direction, width and meaning:
- i_Clk  in  1  single system clock; one clock, reset is synchronous and active-low.
- i_Rst_L  in  1  synchronous active-low reset.
- i_Game_Start  in  1  start button level, debounced upstream.
- i_Collided  in  1  frog/car collision level from the collision checker.
- i_Score  in  7  current frog score.
- o_State  out  2  current game state encoding.
- o_Game_Active  out  1  high when movers and frog control are enabled.
- o_Frog_Reset  out  1  one-cycle pulse that respawns the frog at its origin.
- o_Clear_Score  out  1  one-cycle pulse that zeroes the score.
- o_Lives  out  2  remaining lives.
- o_Game_Over  out  1  sticky loss flag.

Function
REQ-006 All outputs SHALL be registered; every state change SHALL be visible the clock after the triggering input is sampled.
REQ-007 Start SHALL be a rising edge of i_Game_Start (current high, previous-cycle sample low); a held button SHALL produce exactly one edge.
REQ-008 Collision SHALL be a rising edge of i_Collided, detected the same way.
REQ-009 The states SHALL be IDLE=00, RUNNING=01, P1_WINS=10, CLEANUP=11.
REQ-010 IDLE: o_Game_Active=0; on a start edge the block SHALL go to CLEANUP.
REQ-011 CLEANUP, on entry: o_Clear_Score SHALL pulse for one cycle, o_Lives SHALL load c_LIVES, and o_Game_Over SHALL clear.
REQ-012 CLEANUP SHALL last exactly c_CLEANUP_TICKS cycles; on exit o_Frog_Reset SHALL pulse for one cycle and the state SHALL become RUNNING with o_Game_Active=1.
REQ-013 RUNNING, collision edge with the freeze counter at 0 and o_Lives>1: o_Lives SHALL decrement, the freeze counter SHALL load c_DEATH_TICKS, and o_Game_Active SHALL drop to 0.
REQ-014 While the freeze counter is nonzero it SHALL decrement each cycle; on reaching 0, o_Frog_Reset SHALL pulse for one cycle and o_Game_Active SHALL return to 1.
REQ-015 Collision edges during the freeze SHALL be ignored.
REQ-016 RUNNING, collision edge with o_Lives==1: o_Lives SHALL become 0, o_Game_Over SHALL become 1, and the state SHALL go to IDLE with o_Game_Active=0.
REQ-017 RUNNING, i_Score>=c_WIN_SCORE with the freeze counter at 0: the state SHALL go to P1_WINS with o_Game_Active=0.
REQ-018 If a win and a collision occur in the same cycle, the win SHALL take priority and o_Lives SHALL be unchanged.
REQ-019 Start edges SHALL be ignored in RUNNING and CLEANUP.
REQ-020 P1_WINS SHALL hold until a start edge, then go to CLEANUP.
REQ-021 The freeze counter SHALL be sized to hold c_DEATH_TICKS and SHALL saturate at 0 without wrapping.
REQ-022 The CLEANUP counter SHALL be sized to hold c_CLEANUP_TICKS.

Reset
REQ-023 While i_Rst_L=0 at a clock edge, the block SHALL set state=IDLE, o_Lives=c_LIVES, o_Game_Active=0, o_Frog_Reset=0, o_Clear_Score=0, o_Game_Over=0, both counters=0, and edge history=0.
REQ-024 Reset asserted mid-freeze or mid-CLEANUP SHALL abort the operation with no pulse emitted.
REQ-025 A button held through reset release SHALL NOT produce a start edge.

Structure
REQ-026 The state encodings (IDLE, RUNNING, P1_WINS, CLEANUP) and the default c_LIVES and c_WIN_SCORE SHALL reside in shared package frogger_pkg, which the game top and this block both use.
REQ-027 Edge detection SHALL be one reusable sub-module, edge_detect_rise, instantiated twice.

Verification
REQ-028 Reset, then i_Game_Start held high for 100 cycles -> exactly one o_Clear_Score pulse, 16 CLEANUP cycles, one o_Frog_Reset pulse, o_State=01, o_Lives=3.
REQ-029 RUNNING with c_DEATH_TICKS=8, collision pulse -> o_Lives=2, o_Game_Active=0 for 8 cycles, a second collision during the freeze is ignored, then o_Frog_Reset pulses and o_Game_Active=1.
REQ-030 Three spaced collisions -> o_Lives 3->2->1->0, o_Game_Over=1, o_State=00; a following start edge -> o_Game_Over=0, o_Lives=3.
REQ-031 i_Score set to 10 in the same cycle as a collision edge -> o_State=10, o_Lives unchanged; a start edge -> CLEANUP.
REQ-032 i_Rst_L=0 during a freeze with counter=5 -> o_State=00, o_Lives=3, no o_Frog_Reset pulse.
REQ-033 i_Rst_L released while i_Game_Start is already high -> the block stays in IDLE until the button is released and pressed again.
